// File: rtl/delay_pipe.sv
// Multi-channel delay line with a run-time selectable tap, flush, hold and an occupancy count.
// Depth 0 bypasses the storage combinationally; larger selections clamp to MAX_DEPTH.
module delay_pipe #(
   parameter int WIDTH     = 1,
   parameter int NCH       = 1,
   parameter int MAX_DEPTH = 4,
   parameter int NEGEDGE   = 1,
   localparam int DW       = $clog2(MAX_DEPTH + 1),
   localparam int DATA_W   = NCH * WIDTH
) (
   input  logic              _clock,
   input  logic              _reset,
   input  logic              en,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DW-1:0]     depth_sel,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [DW-1:0]     occupancy
);

   logic [MAX_DEPTH-1:0]             valid_q, valid_d;
   logic [MAX_DEPTH-1:0][DATA_W-1:0] data_q, data_d;
   logic [DW-1:0]                    occ_q, occ_d;
   logic [DW-1:0]                    depth_eff;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = '0;
         data_d  = '0;
      end else if (en) begin
         valid_d[0] = in_valid;
         data_d[0]  = in_data;
         for (int i = 1; i < MAX_DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
         end
      end
      // Occupancy is counted from the next state so it lands on the same edge as the stages.
      occ_d = '0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
         occ_d = occ_d + DW'(valid_d[i]);
      end
   end

   generate
      if (NEGEDGE != 0) begin : g_neg
         always_ff @(negedge _clock or posedge _reset) begin
            if (_reset) begin
               valid_q <= '0;
               data_q  <= '0;
               occ_q   <= '0;
            end else begin
               valid_q <= valid_d;
               data_q  <= data_d;
               occ_q   <= occ_d;
            end
         end
      end else begin : g_pos
         always_ff @(posedge _clock or posedge _reset) begin
            if (_reset) begin
               valid_q <= '0;
               data_q  <= '0;
               occ_q   <= '0;
            end else begin
               valid_q <= valid_d;
               data_q  <= data_d;
               occ_q   <= occ_d;
            end
         end
      end
   endgenerate

   // Tap mux; no stage matches when depth_eff is 0, leaving the bypass defaults in place.
   always_comb begin
      depth_eff = (depth_sel > DW'(MAX_DEPTH)) ? DW'(MAX_DEPTH) : depth_sel;
      out_valid = in_valid;
      out_data  = in_data;
      for (int i = 0; i < MAX_DEPTH; i++) begin
         if (depth_eff == DW'(i + 1)) begin
            out_valid = valid_q[i];
            out_data  = data_q[i];
         end
      end
   end

   assign occupancy = occ_q;

endmodule
